// File: rtl/uart_pkg.sv
// Shared UART types and widths used by the transmitter and the programming-UART receiver.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_CPB_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: latches the effective clocks-per-bit on load and flags the last cycle of each bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CPB_W = UART_CPB_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CPB_W-1:0] cpb,
  input  logic             run,
  output logic             bit_end
);

  logic [CPB_W-1:0] cpb_eff_r;
  logic [CPB_W-1:0] count_r;

  // Divisor latch and per-bit cycle counter; a divisor of zero behaves as one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cpb_eff_r <= CPB_W'(1);
      count_r   <= {CPB_W{1'b0}};
    end else if (load) begin
      cpb_eff_r <= (cpb == {CPB_W{1'b0}}) ? CPB_W'(1) : cpb;
      count_r   <= {CPB_W{1'b0}};
    end else if (run) begin
      count_r   <= bit_end ? {CPB_W{1'b0}} : (count_r + CPB_W'(1));
    end else begin
      count_r   <= {CPB_W{1'b0}};
    end
  end

  assign bit_end = run && (count_r == (cpb_eff_r - CPB_W'(1)));

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter (8N1 by default); define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int STOP_BITS = 1,
  parameter int CPB_W     = UART_CPB_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CPB_W-1:0]  io_CLK_PER_BIT,
  input  logic [DATA_W-1:0] io_tx_data_i,
  input  logic              io_tx_valid_i,
  output logic              io_tx_ready_o,
  output logic              io_tx_o,
  output logic              io_tx_busy_o,
  output logic              io_tx_done_o
);

  localparam int BI_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SI_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  tx_state_e         state_r, state_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [BI_W-1:0]   bit_idx_r, bit_idx_s;
  logic [SI_W-1:0]   stop_idx_r, stop_idx_s;
  logic              tx_r, line_s;
  logic              done_r, done_s;
  logic              busy_r;
  logic              bit_end_s;
  logic              last_stop_s;
  logic              ready_s;
  logic              accept_s;

`ifdef UART_TX_PARITY_EN
  logic parity_r;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  assign last_stop_s = (state_r == STOP) && (stop_idx_r == SI_W'(STOP_BITS - 1)) && bit_end_s;
  assign ready_s     = (state_r == IDLE) || last_stop_s;
  assign accept_s    = io_tx_valid_i && ready_s;

  uart_bit_timer #(
    .CPB_W (CPB_W)
  ) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (accept_s),
    .cpb     (io_CLK_PER_BIT),
    .run     (state_r != IDLE),
    .bit_end (bit_end_s)
  );

  // Next-state, shift and line-value decode; the line value follows the next state so the output flop leads cleanly.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    done_s     = 1'b0;
    line_s     = 1'b1;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = START;
          shift_s = io_tx_data_i;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s   = DATA;
          bit_idx_s = {BI_W{1'b0}};
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[DATA_W-1:1]};
          if (bit_idx_r == BI_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_s    = PARITY;
`else
            state_s    = STOP;
`endif
            stop_idx_s = {SI_W{1'b0}};
          end else begin
            bit_idx_s = bit_idx_r + BI_W'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s    = STOP;
          stop_idx_s = {SI_W{1'b0}};
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          if (stop_idx_r == SI_W'(STOP_BITS - 1)) begin
            done_s = 1'b1;
            if (accept_s) begin
              state_s = START;
              shift_s = io_tx_data_i;
            end else begin
              state_s = IDLE;
            end
          end else begin
            stop_idx_s = stop_idx_r + SI_W'(1);
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    case (state_s)
      IDLE:    line_s = 1'b1;
      START:   line_s = 1'b0;
      DATA:    line_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_s = parity_r;
`endif
      STOP:    line_s = 1'b1;
      default: line_s = 1'b1;
    endcase
  end

  // State, data path and output flops; reset abandons any frame and returns the line high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r    <= IDLE;
      shift_r    <= {DATA_W{1'b0}};
      bit_idx_r  <= {BI_W{1'b0}};
      stop_idx_r <= {SI_W{1'b0}};
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      tx_r       <= line_s;
      done_r     <= done_s;
      busy_r     <= (state_s != IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte at accept, since the shift register is consumed during DATA.
  always_ff @(posedge clock) begin
    if (!reset) begin
      parity_r <= 1'b0;
    end else if (accept_s) begin
      parity_r <= even_parity(io_tx_data_i);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  assign io_tx_o       = tx_r;
  assign io_tx_done_o  = done_r;
  assign io_tx_busy_o  = busy_r;
  assign io_tx_ready_o = ready_s;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer (default 8N1 build; parity case under UART_TX_PARITY_EN).
module tb_uart_tx_serializer;

  logic        clock;
  logic        reset;
  logic [15:0] io_CLK_PER_BIT;
  logic [7:0]  io_tx_data_i;
  logic        io_tx_valid_i;
  logic        io_tx_ready_o;
  logic        io_tx_o;
  logic        io_tx_busy_o;
  logic        io_tx_done_o;

  int total;
  int bad;

  logic cap_tx    [0:127];
  logic cap_done  [0:127];
  logic cap_busy  [0:127];
  logic cap_ready [0:127];

  uart_tx_serializer dut (
    .clock          (clock),
    .reset          (reset),
    .io_CLK_PER_BIT (io_CLK_PER_BIT),
    .io_tx_data_i   (io_tx_data_i),
    .io_tx_valid_i  (io_tx_valid_i),
    .io_tx_ready_o  (io_tx_ready_o),
    .io_tx_o        (io_tx_o),
    .io_tx_busy_o   (io_tx_busy_o),
    .io_tx_done_o   (io_tx_done_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte one cycle, confirm ready, let it be accepted; optionally keep valid high.
  task automatic start_byte(input logic [7:0] d, input logic [15:0] cpb, input logic hold, input string tag);
    @(posedge clock);
    #1;
    io_tx_data_i   = d;
    io_CLK_PER_BIT = cpb;
    io_tx_valid_i  = 1'b1;
    check_val({tag, "_ready"}, 32'(io_tx_ready_o), 32'd1);
    @(posedge clock);
    #1;
    if (!hold) io_tx_valid_i = 1'b0;
  endtask

  // Sample n cycles after the accept edge on the falling edge; cycle 0 is the first cycle after accept.
  task automatic capture(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cap_tx[i]    = io_tx_o;
      cap_done[i]  = io_tx_done_o;
      cap_busy[i]  = io_tx_busy_o;
      cap_ready[i] = io_tx_ready_o;
      if (i == drop_at) begin
        @(posedge clock);
        #1;
        io_tx_valid_i = 1'b0;
      end
    end
  endtask

  function automatic int sum_done(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(cap_done[i]);
    return s;
  endfunction

  function automatic int sum_tx(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(cap_tx[i]);
    return s;
  endfunction

  // Each bit period must hold its expected level for all cpb cycles.
  task automatic check_frame(input string tag, input int base, input int cpb, input int nbits,
                             input logic [15:0] pattern);
    for (int j = 0; j < nbits; j++) begin
      check_val($sformatf("%s_bit%0d", tag, j),
                32'(sum_tx(base + j * cpb, base + j * cpb + cpb - 1)),
                pattern[j] ? 32'(cpb) : 32'd0);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b0;
    io_CLK_PER_BIT = 16'd4;
    io_tx_data_i   = 8'h00;
    io_tx_valid_i  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_tx",    32'(io_tx_o),       32'd1);
    check_val("rst_ready", 32'(io_tx_ready_o), 32'd1);
    check_val("rst_busy",  32'(io_tx_busy_o),  32'd0);
    check_val("rst_done",  32'(io_tx_done_o),  32'd0);
    reset = 1'b1;

    // 0xA5 at 4 cycles/bit: 0,1,0,1,0,0,1,0,1,1
    start_byte(8'hA5, 16'd4, 1'b0, "t1");
    capture(42, -1);
    check_frame("t1", 0, 4, 10, 16'h034A);
    check_val("t1_busy_first", 32'(cap_busy[0]),   32'd1);
    check_val("t1_busy_last",  32'(cap_busy[39]),  32'd1);
    check_val("t1_done_early", 32'(sum_done(0, 39)), 32'd0);
    check_val("t1_done_pulse", 32'(cap_done[40]),  32'd1);
    check_val("t1_done_once",  32'(cap_done[41]),  32'd0);
    check_val("t1_busy_after", 32'(cap_busy[40]),  32'd0);
    check_val("t1_idle_line",  32'(cap_tx[41]),    32'd1);

    // divisor 0 behaves as 1
    start_byte(8'hFF, 16'd0, 1'b0, "t2");
    capture(12, -1);
    check_val("t2_start", 32'(cap_tx[0]), 32'd0);
    check_val("t2_data0", 32'(cap_tx[1]), 32'd1);
    check_frame("t2", 0, 1, 10, 16'h03FE);
    check_val("t2_busy9",  32'(cap_busy[9]),  32'd1);
    check_val("t2_busy10", 32'(cap_busy[10]), 32'd0);
    check_val("t2_done_early", 32'(sum_done(0, 9)), 32'd0);
    check_val("t2_done", 32'(cap_done[10]), 32'd1);

    // back-to-back 0x01 then 0x02 at 3 cycles/bit, valid held
    start_byte(8'h01, 16'd3, 1'b1, "t3");
    io_tx_data_i = 8'h02;
    capture(62, 29);
    check_val("t3_ready28", 32'(cap_ready[28]), 32'd0);
    check_val("t3_ready29", 32'(cap_ready[29]), 32'd1);
    check_frame("t3a", 0, 3, 10, 16'h0202);
    check_val("t3_b2b_start", 32'(cap_tx[30]), 32'd0);
    check_val("t3_b2b_busy",  32'(cap_busy[30]), 32'd1);
    check_frame("t3b", 30, 3, 10, 16'h0204);
    check_val("t3_done1", 32'(cap_done[30]), 32'd1);
    check_val("t3_done2", 32'(cap_done[60]), 32'd1);
    check_val("t3_done_cnt", 32'(sum_done(0, 61)), 32'd2);

    // reset during DATA bit 3 at 8 cycles/bit
    start_byte(8'h00, 16'd8, 1'b0, "t4");
    capture(35, -1);
    check_val("t4_mid_low",  32'(cap_tx[33]),   32'd0);
    check_val("t4_mid_busy", 32'(cap_busy[33]), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_val("t4_tx",    32'(io_tx_o),       32'd1);
    check_val("t4_busy",  32'(io_tx_busy_o),  32'd0);
    check_val("t4_ready", 32'(io_tx_ready_o), 32'd1);
    check_val("t4_done",  32'(io_tx_done_o),  32'd0);
    reset = 1'b1;
    capture(50, -1);
    check_val("t4_no_done", 32'(sum_done(0, 49)), 32'd0);
    check_val("t4_idle",    32'(sum_tx(0, 49)),   32'd50);

    // divisor and data changed after accept must not affect the frame in flight
    start_byte(8'h3C, 16'd4, 1'b0, "t5a");
    io_CLK_PER_BIT = 16'd9;
    io_tx_data_i   = 8'hFF;
    capture(42, -1);
    check_frame("t5a", 0, 4, 10, 16'h0278);
    check_val("t5a_done", 32'(cap_done[40]), 32'd1);
    start_byte(8'h5A, 16'd9, 1'b0, "t5b");
    capture(92, -1);
    check_frame("t5b", 0, 9, 10, 16'h02B4);
    check_val("t5b_done_early", 32'(sum_done(0, 89)), 32'd0);
    check_val("t5b_done", 32'(cap_done[90]), 32'd1);

`ifdef UART_TX_PARITY_EN
    // 0x07 with even parity at 2 cycles/bit: 11 bits, parity 1
    start_byte(8'h07, 16'd2, 1'b0, "t6");
    capture(24, -1);
    check_frame("t6", 0, 2, 11, 16'h060E);
    check_val("t6_busy21", 32'(cap_busy[21]), 32'd1);
    check_val("t6_done",   32'(cap_done[22]), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
